// File: rtl/vecmat_collect_pkg.sv
// Shared attention-layer constants and the result record carried through the vector FIFO.
// Collects adder-tree sums into Q/K/V row vectors.
package vecmat_collect_pkg;

    localparam int unsigned DATA_WIDTH  = 16;
    localparam int unsigned VECT_DEPTH  = 64;
    localparam int unsigned ADD_LATENCY = 2;
    localparam int unsigned NUM_WORDS   = 32;
    localparam int unsigned FIFO_DEPTH  = 2;

    localparam int unsigned COL_W  = $clog2(VECT_DEPTH);
    localparam int unsigned TAG_W  = $clog2(NUM_WORDS);
    localparam int unsigned VEC_W  = VECT_DEPTH * DATA_WIDTH;
    localparam int unsigned ASM_W  = VEC_W - DATA_WIDTH;
    localparam int unsigned RES_W  = VEC_W + TAG_W;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W  = CNT_W + 1;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [VEC_W-1:0] data;
    } result_t;

    // Word index advances modulo the sentence length.
    function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] t);
        return (t == TAG_W'(NUM_WORDS - 1)) ? '0 : t + TAG_W'(1);
    endfunction

endpackage

// File: rtl/vecmat_result_fifo.sv
// First-word-fall-through FIFO holding completed result vectors; head is visible
// combinationally from storage and count drives both out_valid and the issue credit.
module vecmat_result_fifo
    import vecmat_collect_pkg::*;
#(
    parameter int unsigned WIDTH = RES_W,
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; stale entries are never visible because count gates them.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

    // The issue credit must make a push into a full FIFO without a pop unreachable.
    always_ff @(posedge clk) begin
        if (reset && push && !pop) assert (count != CW'(DEPTH));
    end

endmodule

// File: rtl/vecmat_collect.sv
// Tags adder-tree sums with a delay-matched valid, packs 64 of them into one row
// vector, buffers rows in a small FIFO and grants issues only with guaranteed space.
module vecmat_collect
    import vecmat_collect_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] sum_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [VEC_W-1:0]      out_data,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  busy
);

    logic [ADD_LATENCY-1:0] vld_sr;
    logic [COL_W-1:0]       iss_cnt;
    logic [COL_W-1:0]       col_cnt;
    logic [CNT_W-1:0]       open_cnt;
    logic [TAG_W-1:0]       tag;
    logic [ASM_W-1:0]       asm_data;
    logic [CNT_W-1:0]       fifo_count;
    logic [SUM_W-1:0]       committed;

    logic    issue;
    logic    vec_open;
    logic    capture;
    logic    push;
    logic    pop;
    result_t push_res;
    result_t head_res;

    assign issue    = in_valid & in_ready;
    assign vec_open = issue & (iss_cnt == '0);
    assign capture  = vld_sr[ADD_LATENCY-1];
    assign push     = capture & (col_cnt == COL_W'(VECT_DEPTH - 1));
    assign pop      = out_valid & out_ready;

    // Vectors already in the FIFO plus vectors still being assembled; a new vector
    // may only open when that total leaves a free slot. Mid-vector issues never stall.
    assign committed = SUM_W'(fifo_count) + SUM_W'(open_cnt);
    assign in_ready  = reset & ((committed < SUM_W'(FIFO_DEPTH)) | (iss_cnt != '0));

    // Valid delay line, issue/column counters, open-vector count and word tag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_sr   <= '0;
            iss_cnt  <= '0;
            col_cnt  <= '0;
            open_cnt <= '0;
            tag      <= '0;
        end else begin
            vld_sr <= (vld_sr << 1) | ADD_LATENCY'(issue);
            if (issue)   iss_cnt <= iss_cnt + COL_W'(1);
            if (capture) col_cnt <= push ? '0 : col_cnt + COL_W'(1);
            case ({vec_open, push})
                2'b10:   open_cnt <= open_cnt + CNT_W'(1);
                2'b01:   open_cnt <= open_cnt - CNT_W'(1);
                default: open_cnt <= open_cnt;
            endcase
            if (push) tag <= next_tag(tag);
        end
    end

    // Assembly holds slots 0..62 only; the last sum goes straight into the FIFO entry.
    always_ff @(posedge clk) begin
        if (capture && !push)
            asm_data[32'(col_cnt) * DATA_WIDTH +: DATA_WIDTH] <= sum_in;
    end

    always_comb begin
        push_res      = '0;
        push_res.tag  = tag;
        push_res.data = {sum_in, asm_data};
    end

    vecmat_result_fifo #(
        .WIDTH (RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_res),
        .pop       (pop),
        .head_data (head_res),
        .count     (fifo_count)
    );

    assign out_valid = reset & (fifo_count != '0);
    assign out_data  = head_res.data;
    assign out_tag   = reset ? head_res.tag : '0;
    assign busy      = reset & ((vld_sr != '0) | (iss_cnt != '0) | (col_cnt != '0)
                              | (open_cnt != '0) | (fifo_count != '0));

endmodule

// File: tb/tb_vecmat_collect.sv
// Directed bench for vecmat_collect: upstream adder-tree delay model, vector
// scoreboard, a cycle table for the single-vector case and hand-written corner cases.
module tb_vecmat_collect;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [15:0]   sum_in;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [1023:0] out_data;
    logic [4:0]    out_tag;
    logic          busy;

    int n_chk = 0;
    int n_fail = 0;
    int pops = 0;

    // Bench-side view of issued columns and the vectors they must form.
    int            tb_col = 0;
    int            tb_nvec = 0;
    int            tb_tag = 0;
    logic [7:0]    seed_base = 8'h00;
    logic [15:0]   issue_val;
    logic [15:0]   drive_val = 16'h0000;
    logic [1023:0] cur_vec = '0;

    typedef struct packed {
        logic [4:0]    tag;
        logic [1023:0] data;
    } exp_t;
    exp_t exp_q[$];

    // Upstream adder tree: 2-cycle pipe, garbage on cycles with no valid result.
    logic [1:0]  pipe_v = 2'b00;
    logic [15:0] pipe_d0 = 16'h0000;
    logic [15:0] pipe_d1 = 16'h0000;

    assign issue_val = {seed_base + 8'(tb_nvec), 8'(tb_col)};
    assign sum_in    = pipe_v[1] ? pipe_d1 : 16'hDEAD;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        pipe_v  <= {pipe_v[0], in_valid & in_ready};
        pipe_d0 <= drive_val;
        pipe_d1 <= pipe_d0;
    end

    vecmat_collect dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_in    (sum_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [1023:0] got, input logic [1023:0] exp);
        int bad;
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            bad = -1;
            for (int k = 63; k >= 0; k--)
                if (got[k*16 +: 16] !== exp[k*16 +: 16]) bad = k;
            $display("FAIL %s: slot %0d got %h required %h", name, bad,
                     got[bad*16 +: 16], exp[bad*16 +: 16]);
        end
    endtask

    // Scoreboard: issues build expected vectors, pops are compared in order.
    initial forever begin
        exp_t e;
        @(negedge clk);
        drive_val = issue_val;
        if (!reset) begin
            tb_col = 0;
            tb_nvec = 0;
            tb_tag = 0;
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_pop: got vector tag %0d required no vector", out_tag);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_tag", 32'(out_tag), 32'(e.tag));
                    chk_vec("sb_data", out_data, e.data);
                end
            end
            if (in_valid && in_ready) begin
                cur_vec[tb_col*16 +: 16] = issue_val;
                if (tb_col == 63) begin
                    exp_q.push_back('{tag: 5'(tb_tag), data: cur_vec});
                    tb_tag = (tb_tag + 1) % 32;
                    tb_nvec++;
                    tb_col = 0;
                end else begin
                    tb_col++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Two reset edges, checks outputs while reset is low; returns at cycle 0.
    task automatic do_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out_tag", 32'(out_tag), 0);
        step();
        reset = 1'b1;
    endtask

    typedef struct {
        int         first;
        int         last;
        logic       iv;
        logic       ordy;
        logic       exp_ir;
        logic       exp_ov;
        logic       exp_busy;
        logic [4:0] exp_tag;
    } row_t;

    row_t          tbl[5];
    logic [1023:0] v1_exp;

    initial begin
        int p0;

        // Single vector: issues in cycles 0..63, sums 16'h0100+k.
        tbl[0] = '{0,  0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0};
        tbl[1] = '{1,  63, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0};
        tbl[2] = '{64, 65, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0};
        tbl[3] = '{66, 66, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0};
        tbl[4] = '{67, 70, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0};
        for (int k = 0; k < 64; k++) v1_exp[k*16 +: 16] = 16'h0100 + 16'(k);

        do_reset();
        seed_base = 8'h01;
        p0 = pops;
        for (int r = 0; r < 5; r++) begin
            for (int c = tbl[r].first; c <= tbl[r].last; c++) begin
                in_valid = tbl[r].iv;
                out_ready = tbl[r].ordy;
                @(negedge clk);
                chk("t1_in_ready", 32'(in_ready), 32'(tbl[r].exp_ir));
                chk("t1_out_valid", 32'(out_valid), 32'(tbl[r].exp_ov));
                chk("t1_busy", 32'(busy), 32'(tbl[r].exp_busy));
                if (tbl[r].exp_ov) begin
                    chk("t1_tag", 32'(out_tag), 32'(tbl[r].exp_tag));
                    chk_vec("t1_data", out_data, v1_exp);
                end
                step();
            end
        end
        chk("t1_pops", 32'(pops - p0), 1);

        // Backpressure: two vectors fill the FIFO, issue stalls at cycle 128.
        do_reset();
        seed_base = 8'h10;
        p0 = pops;
        in_valid = 1'b1;
        for (int c = 0; c <= 140; c++) begin
            @(negedge clk);
            chk("t2_in_ready", 32'(in_ready), 32'(c < 128));
            if (c == 70) chk("t2_tag0_head", 32'(out_tag), 0);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("t2_full_valid", 32'(out_valid), 1);
        chk("t2_full_tag", 32'(out_tag), 0);
        chk("t2_full_busy", 32'(busy), 1);
        step();
        out_ready = 1'b0;
        for (int c = 142; c <= 209; c++) begin
            @(negedge clk);
            chk("t2_in_ready_v2", 32'(in_ready), 32'(c < 206));
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t2_pop_tag1", 32'(out_tag), 1);
        step();
        @(negedge clk);
        chk("t2_pop_tag2", 32'(out_tag), 2);
        chk("t2_valid2", 32'(out_valid), 1);
        step();
        @(negedge clk);
        chk("t2_drained", 32'(out_valid), 0);
        chk("t2_pops", 32'(pops - p0), 3);
        chk("t2_left", 32'(exp_q.size()), 0);

        // Gaps: every other cycle idle, 16'hDEAD on unaligned cycles.
        do_reset();
        seed_base = 8'h30;
        p0 = pops;
        out_ready = 1'b1;
        for (int c = 0; c <= 135; c++) begin
            in_valid = (c < 128) && (c % 2 == 0);
            @(negedge clk);
            if (c == 128) chk("t3_not_yet", 32'(out_valid), 0);
            if (c == 129) begin
                chk("t3_valid", 32'(out_valid), 1);
                chk("t3_slot0", 32'(out_data[15:0]), 32'h3000);
                chk("t3_slot63", 32'(out_data[1023:1008]), 32'h303F);
            end
            step();
        end
        chk("t3_pops", 32'(pops - p0), 1);
        chk("t3_left", 32'(exp_q.size()), 0);

        // Tag wrap: 33 back-to-back vectors.
        do_reset();
        seed_base = 8'h40;
        p0 = pops;
        out_ready = 1'b1;
        for (int c = 0; c <= 2119; c++) begin
            in_valid = (c < 2112);
            @(negedge clk);
            if (c < 2112) chk("t4_in_ready", 32'(in_ready), 1);
            if (c == 2050) chk("t4_tag31", 32'(out_tag), 31);
            if (c == 2114) begin
                chk("t4_wrap_valid", 32'(out_valid), 1);
                chk("t4_tag_wrap", 32'(out_tag), 0);
            end
            step();
        end
        chk("t4_pops", 32'(pops - p0), 33);
        chk("t4_left", 32'(exp_q.size()), 0);

        // Push lands in the same cycle the head pops; a push can never hit a
        // full FIFO, so the full state is reached separately and drained in order.
        do_reset();
        seed_base = 8'h60;
        p0 = pops;
        for (int c = 0; c <= 270; c++) begin
            in_valid = (c < 262);
            out_ready = (c == 129) || (c == 195) || (c == 266) || (c == 267);
            @(negedge clk);
            if (c == 129) chk("t5_head0", 32'(out_tag), 0);
            if (c == 130 || c == 196) begin
                chk("t5_kept_valid", 32'(out_valid), 1);
                chk("t5_in_ready", 32'(in_ready), 1);
            end
            if (c == 130) chk("t5_head1", 32'(out_tag), 1);
            if (c == 196) chk("t5_head2", 32'(out_tag), 2);
            if (c == 265) begin
                chk("t5_full_ready", 32'(in_ready), 0);
                chk("t5_full_tag", 32'(out_tag), 2);
            end
            if (c == 267) chk("t5_second", 32'(out_tag), 3);
            if (c == 268) chk("t5_empty", 32'(out_valid), 0);
            step();
        end
        chk("t5_pops", 32'(pops - p0), 4);
        chk("t5_left", 32'(exp_q.size()), 0);

        // Reset after 40 issues; the next vector holds only fresh values.
        do_reset();
        seed_base = 8'h50;
        p0 = pops;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 40; c++) step();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_rst_in_ready", 32'(in_ready), 0);
        chk("t6_rst_out_valid", 32'(out_valid), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_tag", 32'(out_tag), 0);
        step();
        reset = 1'b1;
        seed_base = 8'hA0;
        for (int c = 41; c <= 110; c++) begin
            in_valid = (c < 105);
            @(negedge clk);
            if (c == 41) chk("t6_busy_clear", 32'(busy), 0);
            chk("t6_out_valid", 32'(out_valid), 32'(c == 107));
            if (c == 107) begin
                chk("t6_tag", 32'(out_tag), 0);
                chk("t6_slot0", 32'(out_data[15:0]), 32'hA000);
                chk("t6_slot39", 32'(out_data[39*16 +: 16]), 32'hA027);
            end
            step();
        end
        chk("t6_pops", 32'(pops - p0), 1);
        chk("t6_left", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
